version_info_streamer: RTL and testbench

//  Serialises a build/version information word into a framed byte stream with a

---
 rtl/version_info_streamer.sv | 193 +++++++++++++++++++
 tb/tb_version_info_streamer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/version_info_streamer.sv
// version_info_streamer
// Serialises a snapshotted build/version info word into a framed byte stream
// (SYNC, LEN, payload MS-byte first, CHK) behind a valid/ready handshake.
// Frames are started by a request pulse or by an optional periodic timer.
module version_info_streamer #(
    parameter int         INFO_BYTES    = 4,
    parameter int         PERIOD_CYCLES = 0,
    parameter logic [7:0] SYNC_BYTE     = 8'hA5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    req,
    input  logic [INFO_BYTES*8-1:0] info_i,
    output logic [7:0]              m_data,
    output logic                    m_valid,
    output logic                    m_last,
    input  logic                    m_ready,
    output logic                    busy,
    output logic [15:0]             frame_cnt
);

    localparam int          W           = INFO_BYTES * 8;
    localparam logic [7:0]  LEN_BYTE    = 8'(INFO_BYTES);
    localparam logic [7:0]  LAST_IDX    = 8'(INFO_BYTES - 1);
    localparam logic        PERIOD_EN   = (PERIOD_CYCLES > 0) ? 1'b1 : 1'b0;
    localparam logic [31:0] PERIOD_LAST = (PERIOD_CYCLES > 0) ? 32'(PERIOD_CYCLES - 1) : 32'd0;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SYNC = 3'd1,
        LEN  = 3'd2,
        PAY  = 3'd3,
        CHK  = 3'd4
    } state_t;

    // Running checksum accumulation (mod 256).
    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

    // Final checksum byte: makes LEN + payload + CHK == 0 mod 256.
    function automatic logic [7:0] csum_final(input logic [7:0] acc);
        return 8'd0 - acc;
    endfunction

    state_t         state_r;
    logic [W-1:0]   snap_r;
    logic [7:0]     idx_r;
    logic [7:0]     sum_r;
    logic           pending_r;
    logic [31:0]    period_cnt_r;

    logic           period_hit_s;
    logic           trig_s;
    logic           start_s;
    logic           accept_s;
    logic [7:0]     top_byte_s;

    assign accept_s   = m_valid && m_ready;
    assign top_byte_s = snap_r[W-1 -: 8];

    // Trigger sources are only honoured while the block is enabled.
    always_comb begin
        period_hit_s = 1'b0;
        trig_s       = 1'b0;
        if (en) begin
            period_hit_s = PERIOD_EN && (period_cnt_r == PERIOD_LAST);
            trig_s       = req || period_hit_s;
        end else begin
            period_hit_s = 1'b0;
            trig_s       = 1'b0;
        end
    end

    // A frame starts from IDLE, or back-to-back straight after CHK is accepted.
    always_comb begin
        start_s = 1'b0;
        if (en && (pending_r || trig_s)) begin
            start_s = (state_r == IDLE) || ((state_r == CHK) && accept_s);
        end else begin
            start_s = 1'b0;
        end
    end

    // Free-running period counter, parked at zero while disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_cnt_r <= 32'd0;
        end else if (!en || !PERIOD_EN) begin
            period_cnt_r <= 32'd0;
        end else if (period_cnt_r == PERIOD_LAST) begin
            period_cnt_r <= 32'd0;
        end else begin
            period_cnt_r <= period_cnt_r + 32'd1;
        end
    end

    // One-deep pending flag; a trigger coinciding with consumption is retained.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_r <= 1'b0;
        end else if (!en) begin
            pending_r <= 1'b0;
        end else if (start_s) begin
            pending_r <= pending_r && trig_s;
        end else if (trig_s) begin
            pending_r <= 1'b1;
        end
    end

    // Frame FSM with registered stream outputs, snapshot and checksum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            snap_r    <= '0;
            idx_r     <= 8'd0;
            sum_r     <= 8'd0;
            m_data    <= 8'd0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            busy      <= 1'b0;
            frame_cnt <= 16'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        snap_r  <= info_i;
                        m_data  <= SYNC_BYTE;
                        m_valid <= 1'b1;
                        m_last  <= 1'b0;
                        busy    <= 1'b1;
                        state_r <= SYNC;
                    end
                end
                SYNC: begin
                    if (accept_s) begin
                        m_data  <= LEN_BYTE;
                        state_r <= LEN;
                    end
                end
                LEN: begin
                    if (accept_s) begin
                        m_data  <= top_byte_s;
                        sum_r   <= csum_add(LEN_BYTE, top_byte_s);
                        snap_r  <= snap_r << 8;
                        idx_r   <= 8'd0;
                        state_r <= PAY;
                    end
                end
                PAY: begin
                    if (accept_s) begin
                        if (idx_r == LAST_IDX) begin
                            m_data  <= csum_final(sum_r);
                            m_last  <= 1'b1;
                            state_r <= CHK;
                        end else begin
                            m_data <= top_byte_s;
                            sum_r  <= csum_add(sum_r, top_byte_s);
                            snap_r <= snap_r << 8;
                            idx_r  <= idx_r + 8'd1;
                        end
                    end
                end
                CHK: begin
                    if (accept_s) begin
                        frame_cnt <= frame_cnt + 16'd1;
                        if (start_s) begin
                            snap_r  <= info_i;
                            m_data  <= SYNC_BYTE;
                            m_valid <= 1'b1;
                            m_last  <= 1'b0;
                            busy    <= 1'b1;
                            state_r <= SYNC;
                        end else begin
                            m_valid <= 1'b0;
                            m_last  <= 1'b0;
                            busy    <= 1'b0;
                            state_r <= IDLE;
                        end
                    end
                end
                default: begin
                    m_valid <= 1'b0;
                    m_last  <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_version_info_streamer.sv
// Self-checking bench for version_info_streamer: table-driven byte vectors
// plus hand-written sequences for collapse, snapshot, reset and periodic send.
module tb_version_info_streamer;

    logic        clk = 1'b0;
    logic        rst;
    logic        en, req, m_ready;
    logic [31:0] info;
    logic [7:0]  m_data;
    logic        m_valid, m_last, busy;
    logic [15:0] frame_cnt;

    logic        en_p, req_p, m_ready_p;
    logic [31:0] info_p;
    logic [7:0]  m_data_p;
    logic        m_valid_p, m_last_p, busy_p;
    logic [15:0] frame_cnt_p;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    version_info_streamer #(.INFO_BYTES(4), .PERIOD_CYCLES(0), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .rst(rst), .en(en), .req(req), .info_i(info),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
        .busy(busy), .frame_cnt(frame_cnt)
    );

    version_info_streamer #(.INFO_BYTES(4), .PERIOD_CYCLES(100), .SYNC_BYTE(8'hA5)) dut_p (
        .clk(clk), .rst(rst), .en(en_p), .req(req_p), .info_i(info_p),
        .m_data(m_data_p), .m_valid(m_valid_p), .m_last(m_last_p), .m_ready(m_ready_p),
        .busy(busy_p), .frame_cnt(frame_cnt_p)
    );

    typedef struct packed {
        logic        req;
        logic        rdy;
        logic        exp_valid;
        logic [7:0]  exp_data;
        logic        exp_last;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t       vecs [0:23];
    logic [7:0] got   [0:15];
    logic [7:0] exp_f [0:6];
    int         got_n;
    int         last_at;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Records accepted bytes on the main DUT for a fixed window.
    task automatic collect_frame(input int cycles);
        got_n   = 0;
        last_at = -1;
        for (int c = 0; c < cycles; c++) begin
            if (m_valid && m_ready) begin
                if (got_n < 16) got[got_n] = m_data;
                if (m_last) last_at = got_n;
                got_n++;
            end
            tick();
        end
    endtask

    task automatic check_frame(input string name);
        check({name, "_nbytes"}, 32'(got_n), 32'd7);
        check({name, "_last_pos"}, 32'(last_at), 32'd6);
        for (int k = 0; k < 7; k++) begin
            if (k < got_n) check($sformatf("%s_byte%0d", name, k), 32'(got[k]), 32'(exp_f[k]));
            else check($sformatf("%s_byte%0d_missing", name, k), 32'd0, 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    initial begin
        int accepts;
        int syncs;
        int frames_exp;
        int sync_at [0:7];
        int nsync;
        int first_sync;

        // Test 1 (rows 0..8) then test 2 with m_ready toggling (rows 9..23).
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 16'd0};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 16'd0};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 8'h04, 1'b0, 16'd0};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 8'h01, 1'b0, 16'd0};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 16'd0};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 16'd0};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 8'h4D, 1'b0, 16'd0};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 8'hAE, 1'b1, 16'd0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 16'd1};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'd1};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 16'd1};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 8'h04, 1'b0, 16'd1};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 8'h04, 1'b0, 16'd1};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 16'd1};
        vecs[14] = '{1'b0, 1'b1, 1'b1, 8'h01, 1'b0, 16'd1};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 16'd1};
        vecs[16] = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 16'd1};
        vecs[17] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 16'd1};
        vecs[18] = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 16'd1};
        vecs[19] = '{1'b0, 1'b0, 1'b1, 8'h4D, 1'b0, 16'd1};
        vecs[20] = '{1'b0, 1'b1, 1'b1, 8'h4D, 1'b0, 16'd1};
        vecs[21] = '{1'b0, 1'b0, 1'b1, 8'hAE, 1'b1, 16'd1};
        vecs[22] = '{1'b0, 1'b1, 1'b1, 8'hAE, 1'b1, 16'd1};
        vecs[23] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'd2};

        rst = 1'b1; en = 1'b1; req = 1'b0; m_ready = 1'b0; info = 32'h0100004D;
        en_p = 1'b1; req_p = 1'b0; m_ready_p = 1'b1; info_p = 32'h0100004D;
        tick(); tick(); tick();

        // Reset state.
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_last",  32'(m_last),  32'd0);
        check("rst_data",  32'(m_data),  32'd0);
        check("rst_busy",  32'(busy),    32'd0);
        check("rst_cnt",   32'(frame_cnt), 32'd0);
        rst = 1'b0;
        tick(); tick();
        check("idle_valid", 32'(m_valid), 32'd0);

        // Table-driven frames.
        accepts = 0;
        for (int i = 0; i < 24; i++) begin
            req     = vecs[i].req;
            m_ready = vecs[i].rdy;
            check($sformatf("v%0d_valid", i), 32'(m_valid), 32'(vecs[i].exp_valid));
            check($sformatf("v%0d_busy", i),  32'(busy),    32'(vecs[i].exp_valid));
            check($sformatf("v%0d_last", i),  32'(m_last),  32'(vecs[i].exp_last));
            check($sformatf("v%0d_cnt", i),   32'(frame_cnt), 32'(vecs[i].exp_cnt));
            if (vecs[i].exp_valid) check($sformatf("v%0d_data", i), 32'(m_data), 32'(vecs[i].exp_data));
            if (i >= 9 && m_valid && m_ready) accepts++;
            tick();
        end
        req = 1'b0;
        check("t2_accepts", 32'(accepts), 32'd7);
        frames_exp = 2;

        // Test 3: three requests during a frame collapse into one extra frame.
        m_ready = 1'b1;
        req = 1'b1;
        tick();
        syncs = 0;
        for (int c = 1; c <= 16; c++) begin
            req = (c == 2 || c == 3 || c == 5) ? 1'b1 : 1'b0;
            if (m_valid && m_data == 8'hA5 && !m_last) syncs++;
            if (c == 7) begin
                check("t3_chk_valid", 32'(m_valid), 32'd1);
                check("t3_chk_last",  32'(m_last),  32'd1);
                check("t3_chk_data",  32'(m_data),  32'hAE);
            end
            if (c == 8) begin
                check("t3_b2b_valid", 32'(m_valid), 32'd1);
                check("t3_b2b_data",  32'(m_data),  32'hA5);
            end
            if (c == 15) check("t3_idle_valid", 32'(m_valid), 32'd0);
            tick();
        end
        req = 1'b0;
        frames_exp += 2;
        check("t3_syncs", 32'(syncs), 32'd2);
        check("t3_cnt", 32'(frame_cnt), 32'(frames_exp));

        // Test 5: info changed mid-frame; the sampled value is transmitted.
        info = 32'h12345678;
        req  = 1'b1;
        tick();
        req  = 1'b0;
        info = 32'hDEADBEEF;
        exp_f[0] = 8'hA5; exp_f[1] = 8'h04; exp_f[2] = 8'h12; exp_f[3] = 8'h34;
        exp_f[4] = 8'h56; exp_f[5] = 8'h78; exp_f[6] = 8'hE8;
        collect_frame(12);
        check_frame("t5");
        frames_exp += 1;
        check("t5_cnt", 32'(frame_cnt), 32'(frames_exp));

        // en=0: requests ignored and no stale pending after re-enable.
        en  = 1'b0;
        req = 1'b1;
        tick();
        req = 1'b0;
        tick(); tick(); tick();
        en  = 1'b1;
        syncs = 0;
        for (int c = 0; c < 10; c++) begin
            if (m_valid) syncs++;
            tick();
        end
        check("en0_no_frame", 32'(syncs), 32'd0);

        // Test 6: async reset during PAY aborts the frame.
        info = 32'h0100004D;
        req  = 1'b1;
        tick();
        req  = 1'b0;
        tick(); tick();
        check("t6_in_pay", 32'(m_data), 32'h01);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_valid", 32'(m_valid), 32'd0);
        check("t6_rst_busy",  32'(busy),    32'd0);
        check("t6_rst_cnt",   32'(frame_cnt), 32'd0);
        tick();
        rst = 1'b0;
        tick(); tick();
        check("t6_no_resume", 32'(m_valid), 32'd0);
        req = 1'b1;
        tick();
        req = 1'b0;
        check("t6_new_sync", 32'(m_data), 32'hA5);
        exp_f[0] = 8'hA5; exp_f[1] = 8'h04; exp_f[2] = 8'h01; exp_f[3] = 8'h00;
        exp_f[4] = 8'h00; exp_f[5] = 8'h4D; exp_f[6] = 8'hAE;
        collect_frame(12);
        check_frame("t6");
        check("t6_cnt", 32'(frame_cnt), 32'd1);

        // Test 4: periodic frames every 100 cycles, none while disabled.
        nsync = 0;
        for (int c = 0; c < 350; c++) begin
            if (m_valid_p && m_data_p == 8'hA5 && !m_last_p) begin
                if (nsync < 8) sync_at[nsync] = c;
                nsync++;
            end
            tick();
        end
        check("t4_nsync_ge3", 32'(nsync >= 3), 32'd1);
        for (int k = 1; k < 3; k++) begin
            if (k < nsync) check($sformatf("t4_interval%0d", k), 32'(sync_at[k] - sync_at[k-1]), 32'd100);
        end
        en_p = 1'b0;
        syncs = 0;
        for (int c = 0; c < 300; c++) begin
            if (c > 0 && m_valid_p && m_data_p == 8'hA5 && !m_last_p) syncs++;
            tick();
        end
        check("t4_en0_no_sync", 32'(syncs), 32'd0);
        en_p = 1'b1;
        first_sync = -1;
        for (int c = 0; c < 200; c++) begin
            if (first_sync < 0 && m_valid_p && m_data_p == 8'hA5 && !m_last_p) first_sync = c;
            tick();
        end
        check("t4_reenable_delay", 32'(first_sync), 32'd100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
